regfile_wport_sched: RTL

- Write-port scheduler and scoreboard for the single-write-port 32x32 register file in the stall/forward pipeline.
- Shares write port A3/WD3/WE3 between the in-order pipeline writeback (priority) and results from a long-latency unit (multi-cycle mul/div or slow load), which are buffered in a small FIFO.
- Tracks registers awaiting long-latency results and raises decode stalls, so the hazard unit never reads stale data.

---
 rtl/regfile_wport_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_wport_sched.sv
// Write-port scheduler and scoreboard for the single-write-port 32x32
// register file. Pipeline writeback owns the port; long-latency results are
// buffered and drained whenever the pipeline leaves the port idle. A busy
// scoreboard stalls decode/issue on registers whose results are still
// outstanding, and a starvation timer asks the pipeline to back off when the
// buffer head has been denied the port for too long.
module regfile_wport_sched #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_a,
  input  logic [31:0] wb_wd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_a,
  input  logic [31:0] lu_wd,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        stall_d,
  output logic        issue_stall,
  output logic        hold_pipe
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [TW-1:0] LIMIT_C = TW'(STARVE_LIMIT);
  localparam logic [TW-1:0] ONE_C   = TW'(1);

  logic [4:0]    buf_a  [BUF_DEPTH];
  logic [31:0]   buf_wd [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic [TW-1:0] starve_tmr;
  logic          hold_q;

  logic          fifo_empty;
  logic          wb_grant;
  logic          pop;
  logic          push;
  logic          denied;
  logic          issue_set;
  logic [4:0]    head_a;
  logic [31:0]   head_wd;

  // Port arbitration, FIFO handshake and stall decode; reset masks everything.
  always_comb begin
    fifo_empty  = (count == '0);
    head_a      = buf_a[rd_ptr];
    head_wd     = buf_wd[rd_ptr];
    wb_grant    = !reset && wb_we && (wb_a != 5'd0);
    pop         = !reset && !fifo_empty && !wb_grant;
    denied      = !fifo_empty && wb_grant;
    lu_ready    = !reset && (count < DEPTH_C);
    push        = lu_valid && lu_ready;
    stall_d     = !reset && (busy[rs_d] || busy[rt_d]);
    issue_stall = !reset && issue_valid && busy[issue_dst];
    issue_set   = !reset && issue_valid && !busy[issue_dst] && (issue_dst != 5'd0);
    WE3         = 1'b0;
    A3          = 5'd0;
    WD3         = 32'd0;
    if (wb_grant) begin
      WE3 = 1'b1;
      A3  = wb_a;
      WD3 = wb_wd;
    end else if (pop) begin
      // An entry for r0 still drains, it just never writes.
      WE3 = (head_a != 5'd0);
      A3  = head_a;
      WD3 = head_wd;
    end
  end

  // Scoreboard next value: commit clears, issue sets, set applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head_a] = 1'b0;
    if (issue_set) busy_nxt[issue_dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Result buffer storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_a[wr_ptr]  <= lu_a;
      buf_wd[wr_ptr] <= lu_wd;
    end
  end

  // Result buffer pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Starvation timer counts down denied cycles; hold latches at terminal count until a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_tmr <= LIMIT_C;
      hold_q     <= 1'b0;
    end else if (pop) begin
      starve_tmr <= LIMIT_C;
      hold_q     <= 1'b0;
    end else if (fifo_empty) begin
      starve_tmr <= LIMIT_C;
    end else if (denied) begin
      if (starve_tmr != '0) starve_tmr <= starve_tmr - 1'b1;
      if (starve_tmr == ONE_C) hold_q <= 1'b1;
    end
  end

  assign hold_pipe = hold_q;

endmodule
